uart_tx_ext: RTL and testbench

UART_TX_EXT -- requirements
Module: uart_tx_ext

---
 rtl/uart_tx_ext.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_ext.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ext.sv
// uart_tx_ext: FIFO-buffered UART transmitter with selectable parity and one or two stop bits.
// Frame settings are captured when a byte leaves the FIFO, so they stay fixed for that whole frame.
module uart_tx_ext #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop2,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned DIV    = CLK_FREQ / BAUD_RATE;
  localparam int unsigned BAUD_W = $clog2(2 * DIV);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam logic [7:0]  DATA_MASK = 8'((1 << DATA_BITS) - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t             r_state;
  state_t             w_state_nx;

  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_nx;
  logic               r_wr_ready;

  logic [7:0]         r_shift;
  logic               r_par;
  logic               r_par_en;
  logic               r_stop2;
  logic [BAUD_W-1:0]  r_baud;
  logic [BAUD_W-1:0]  w_baud_lim;
  logic [BIT_W-1:0]   r_bit;
  logic               r_tx;
  logic               r_busy;

  logic               w_push;
  logic               w_pop;
  logic               w_fifo_nempty;
  logic               w_period_end;
  logic               w_last_bit;
  logic               w_tx_nx;
  logic [7:0]         w_head;

  assign w_push        = wr_valid && r_wr_ready;
  assign w_fifo_nempty = (r_count != '0);
  assign w_head        = r_mem[r_rd_ptr];
  assign w_period_end  = (r_baud == w_baud_lim);
  assign w_last_bit    = (r_bit == BIT_W'(DATA_BITS - 1));

  assign wr_ready   = r_wr_ready;
  assign tx         = r_tx;
  assign busy       = r_busy;
  assign fifo_count = r_count;

  // The second stop bit is folded into one double-length STOP period.
  always_comb begin
    w_baud_lim = BAUD_W'(DIV - 1);
    if (r_state == S_STOP && r_stop2) w_baud_lim = BAUD_W'(2 * DIV - 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   if (w_fifo_nempty) w_state_nx = S_START;
      S_START:  if (w_period_end) w_state_nx = S_DATA;
      S_DATA:   if (w_period_end && w_last_bit) w_state_nx = r_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (w_period_end) w_state_nx = S_STOP;
      S_STOP:   if (w_period_end) w_state_nx = w_fifo_nempty ? S_START : S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  // Line level is a one-cycle-delayed image of the state, giving the two-edge start latency.
  always_comb begin
    w_pop   = 1'b0;
    w_tx_nx = 1'b1;
    case (r_state)
      S_IDLE:   w_pop   = w_fifo_nempty;
      S_START:  w_tx_nx = 1'b0;
      S_DATA:   w_tx_nx = r_shift[0];
      S_PARITY: w_tx_nx = r_par;
      S_STOP:   w_pop   = w_period_end && w_fifo_nempty;
      default:  w_tx_nx = 1'b1;
    endcase
  end

  always_comb begin
    w_count_nx = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nx = r_count + CNT_W'(1);
      2'b01:   w_count_nx = r_count - CNT_W'(1);
      default: w_count_nx = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_wr_ready <= 1'b1;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_par_en   <= 1'b0;
      r_stop2    <= 1'b0;
      r_baud     <= '0;
      r_bit      <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count    <= w_count_nx;
      r_wr_ready <= (w_count_nx != CNT_W'(FIFO_DEPTH));
      r_busy     <= (w_state_nx != S_IDLE) || (w_count_nx != '0);
      r_tx       <= w_tx_nx;

      if (r_state == S_IDLE || w_period_end) r_baud <= '0;
      else                                   r_baud <= r_baud + BAUD_W'(1);

      if (r_state != S_DATA)  r_bit <= '0;
      else if (w_period_end)  r_bit <= r_bit + BIT_W'(1);

      if (w_pop) begin
        r_shift  <= w_head;
        r_par_en <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
        r_par    <= (parity_mode == 2'b01) ^ (^(w_head & DATA_MASK));
        r_stop2  <= stop2;
      end else if (r_state == S_DATA && w_period_end) begin
        r_shift  <= {1'b0, r_shift[7:1]};
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_ext.sv
// Bench for uart_tx_ext: a per-cycle line monitor decodes frames against a scoreboard of written bytes.
module tb_uart_tx_ext;

  localparam int unsigned DIV = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] wr_data;
  logic       wr_valid0, wr_valid1;
  logic [1:0] parity_mode;
  logic       stop2;
  logic       rdy0, rdy1, tx0, tx1, busy0, busy1;
  logic [2:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int frames_done = 0;
  int start_log[$];

  typedef struct {
    int         dut;
    logic [7:0] data;
    logic [1:0] pm;
    logic       s2;
    int         nbits;
  } exp_t;
  exp_t sb_q[$];

  uart_tx_ext #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8), .FIFO_DEPTH(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_valid(wr_valid0), .wr_ready(rdy0),
    .parity_mode(parity_mode), .stop2(stop2), .tx(tx0), .busy(busy0), .fifo_count(cnt0)
  );

  uart_tx_ext #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(5), .FIFO_DEPTH(4)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_valid(wr_valid1), .wr_ready(rdy1),
    .parity_mode(parity_mode), .stop2(stop2), .tx(tx1), .busy(busy1), .fifo_count(cnt1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Decode each frame cycle by cycle against the bit pattern the scoreboard entry implies.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    logic       act = 1'b0;
    logic       skip = 1'b0;
    logic       bits [16];
    int         pos, len, bad, ones;
    logic [7:0] cur;
    always @(negedge clk) begin
      logic t;
      exp_t e;
      t = (g == 0) ? tx0 : tx1;
      if (!rst_n) begin
        act  = 1'b0;
        skip = 1'b0;
      end else begin
        if (skip && t === 1'b1) skip = 1'b0;
        if (!act && !skip && t === 1'b0) begin
          if (sb_q.size() == 0 || sb_q[0].dut != g) begin
            chk($sformatf("unexpected_start_dut%0d", g), 32'd1, 32'd0);
            skip = 1'b1;
          end else begin
            e = sb_q.pop_front();
            cur = e.data;
            len = 0; ones = 0;
            bits[len] = 1'b0; len++;
            for (int i = 0; i < e.nbits; i++) begin
              bits[len] = e.data[i];
              ones += int'(e.data[i]);
              len++;
            end
            if (e.pm == 2'b01) begin bits[len] = 1'((ones % 2) == 0); len++; end
            else if (e.pm == 2'b10) begin bits[len] = 1'((ones % 2) == 1); len++; end
            bits[len] = 1'b1; len++;
            if (e.s2) begin bits[len] = 1'b1; len++; end
            act = 1'b1; pos = 0; bad = 0;
            start_log.push_back(cyc);
          end
        end
        if (act) begin
          if (t !== bits[pos / DIV]) bad++;
          pos++;
          if (pos == len * DIV) begin
            chk($sformatf("frame_dut%0d_%02h_bad_cycles", g, cur), 32'(bad), 32'd0);
            act = 1'b0;
            frames_done++;
          end
        end
      end
    end
  end

  task automatic send(input int d, input logic [7:0] b);
    int n = 0;
    while (!(d == 0 ? rdy0 : rdy1) && n < 4000) begin @(posedge clk); #1; n++; end
    chk($sformatf("wr_ready_wait_%02h", b), 32'(d == 0 ? rdy0 : rdy1), 32'd1);
    wr_data = b;
    if (d == 0) wr_valid0 = 1'b1; else wr_valid1 = 1'b1;
    @(posedge clk);
    sb_q.push_back('{dut: d, data: b, pm: parity_mode, s2: stop2, nbits: (d == 0) ? 8 : 5});
    #1;
    wr_valid0 = 1'b0;
    wr_valid1 = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_frames(input int n);
    int t = 0;
    while (frames_done < n && t < 5000) begin @(negedge clk); t++; end
    chk("frames_done", 32'(frames_done), 32'(n));
  endtask

  initial begin
    int base, acc0, t;
    rst_n = 1'b0; wr_data = '0; wr_valid0 = 1'b0; wr_valid1 = 1'b0;
    parity_mode = 2'b00; stop2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx0), 32'd1);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_count", 32'(cnt0), 32'd0);
    chk("rst_ready", 32'(rdy0), 32'd1);
    chk("rst_tx5", 32'(tx1), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 8N1 single byte, latency and busy release
    send(0, 8'hA5);
    acc0 = acc_cyc;
    @(negedge clk);
    chk("busy_after_write", 32'(busy0), 32'd1);
    wait_frames(1);
    chk("start_latency", 32'(start_log[0] - acc0), 32'd2);
    chk("busy_after_frame", 32'(busy0), 32'd0);
    chk("tx_idle_after_frame", 32'(tx0), 32'd1);

    // odd then even parity
    parity_mode = 2'b01;
    send(0, 8'h03);
    wait_frames(2);
    parity_mode = 2'b10;
    send(0, 8'h03);
    wait_frames(3);
    chk("busy_after_parity", 32'(busy0), 32'd0);

    // back-to-back burst into a depth-4 FIFO, then a dropped write while full
    parity_mode = 2'b00;
    base = start_log.size();
    send(0, 8'h11); acc0 = acc_cyc;
    send(0, 8'h22); send(0, 8'h33); send(0, 8'h44); send(0, 8'h55);
    chk("count_full", 32'(cnt0), 32'd4);
    chk("ready_full", 32'(rdy0), 32'd0);
    wr_data = 8'h99; wr_valid0 = 1'b1;
    @(posedge clk); #1;
    wr_valid0 = 1'b0;
    chk("count_after_drop", 32'(cnt0), 32'd4);
    wait_frames(8);
    chk("burst_latency", 32'(start_log[base] - acc0), 32'd2);
    for (int i = 1; i < 5; i++)
      chk($sformatf("burst_gap_%0d", i), 32'(start_log[base+i] - start_log[base+i-1]), 32'd160);

    // two stop bits; settings changed mid-frame must not alter the frame on the line
    stop2 = 1'b1;
    base = start_log.size();
    send(0, 8'hFF);
    send(0, 8'h00);
    t = 0;
    while (start_log.size() < base + 2 && t < 1000) begin @(negedge clk); t++; end
    stop2 = 1'b0;
    parity_mode = 2'b01;
    wait_frames(10);
    chk("stop2_gap", 32'(start_log[base+1] - start_log[base]), 32'd176);

    // reset in the middle of a frame with three bytes queued
    parity_mode = 2'b00;
    base = start_log.size();
    send(0, 8'h01); send(0, 8'h02); send(0, 8'h03); send(0, 8'h04);
    t = 0;
    while (start_log.size() < base + 1 && t < 100) begin @(negedge clk); t++; end
    while (cyc < start_log[base] + 50 && t < 400) begin @(posedge clk); t++; end
    #1;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk("midrst_tx", 32'(tx0), 32'd1);
    chk("midrst_count", 32'(cnt0), 32'd0);
    chk("midrst_busy", 32'(busy0), 32'd0);
    chk("midrst_ready", 32'(rdy0), 32'd1);
    wr_data = 8'h77; wr_valid0 = 1'b1;
    @(posedge clk); #1;
    wr_valid0 = 1'b0;
    chk("no_write_in_reset", 32'(cnt0), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    base = start_log.size();
    send(0, 8'h5A); acc0 = acc_cyc;
    wait_frames(11);
    chk("post_reset_latency", 32'(start_log[base] - acc0), 32'd2);
    chk("post_reset_busy", 32'(busy0), 32'd0);

    // five data bits: upper bits ignored, parity over the low five only
    base = start_log.size();
    send(1, 8'hFF); acc0 = acc_cyc;
    wait_frames(12);
    chk("db5_latency", 32'(start_log[base] - acc0), 32'd2);
    chk("db5_busy_end", 32'(busy1), 32'd0);
    parity_mode = 2'b10;
    send(1, 8'hE1);
    wait_frames(13);
    chk("db5_parity_busy_end", 32'(busy1), 32'd0);

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
